data_memory_ctrl: RTL

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressed, big-endian data memory behind a MIPS load/store decoder.
//   Each access walks IDLE -> ACCESS -> RESP, so a response appears two
//   cycles after the request is accepted and a new request can be taken
//   every third cycle.
//
// Parameters
//   DEPTH : memory size in bytes (power of two, 4..65536)
//   AW    : byte-address bits used (log2 DEPTH)
//
// Ports
//   clk, reset_n       : clock and asynchronous active-low reset
//   req_valid/req_ready: request handshake (ready only while IDLE)
//   opcode             : MIPS opcode [31:26] of lb/lh/lw/lbu/lhu/sb/sh/sw
//   addr, wdata        : byte address and right-justified store data
//   rsp_valid          : single-cycle response strobe
//   rdata              : extended load result (zero unless a load responds)
//   rsp_err            : access rejected (undecoded op, out of range,
//                        or misaligned when alignment checking is enabled)
//
// Configuration
//   DMEM_ALIGN_CHECK_EN : when defined, misaligned halfword/word accesses
//                         are rejected instead of proceeding bytewise.

module data_memory_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;

  logic [5:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [7:0]    mem [DEPTH];

  logic          op_ok;
  logic          is_store;
  logic          sign_ext;
  logic [2:0]    nbytes;
  logic [AW:0]   last_addr;
  logic          out_of_range;
  logic          misaligned;
  logic          access_err;
  logic [AW-1:0] byte_addr [4];
  logic [7:0]    rd_byte [4];
  logic [7:0]    wr_byte [4];
  logic [31:0]   load_val;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are gated by state so reset forces them to zero at once
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && err_q;
    rdata     = (state == RESP) ? rdata_q : 32'h0;
  end

  // Opcode decode of the captured request
  always_comb begin
    op_ok    = 1'b1;
    is_store = 1'b0;
    sign_ext = 1'b0;
    nbytes   = 3'd1;
    case (op_q)
      6'b100000: begin sign_ext = 1'b1; nbytes = 3'd1; end
      6'b100001: begin sign_ext = 1'b1; nbytes = 3'd2; end
      6'b100011: nbytes = 3'd4;
      6'b100100: nbytes = 3'd1;
      6'b100101: nbytes = 3'd2;
      6'b101000: begin is_store = 1'b1; nbytes = 3'd1; end
      6'b101001: begin is_store = 1'b1; nbytes = 3'd2; end
      6'b101011: begin is_store = 1'b1; nbytes = 3'd4; end
      default:   op_ok = 1'b0;
    endcase
  end

  // Error checks; the extra MSB of last_addr catches accesses running
  // past the top of the array
  always_comb begin
    last_addr    = {1'b0, addr_q[AW-1:0]} + (AW+1)'(nbytes - 3'd1);
    out_of_range = (addr_q[31:AW] != '0) || last_addr[AW];
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned   = ((nbytes == 3'd2) && addr_q[0]) ||
                   ((nbytes == 3'd4) && (addr_q[1:0] != 2'b00));
`else
    misaligned   = 1'b0;
`endif
    access_err   = !op_ok || out_of_range || misaligned;
  end

  // Big-endian lane mapping: lane 0 is the byte at addr and the most
  // significant byte of the accessed unit
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = addr_q[AW-1:0] + AW'(i);
      rd_byte[i]   = mem[byte_addr[i]];
      wr_byte[i]   = 8'h00;
    end
    case (nbytes)
      3'd1: wr_byte[0] = wdata_q[7:0];
      3'd2: begin
        wr_byte[0] = wdata_q[15:8];
        wr_byte[1] = wdata_q[7:0];
      end
      default: begin
        wr_byte[0] = wdata_q[31:24];
        wr_byte[1] = wdata_q[23:16];
        wr_byte[2] = wdata_q[15:8];
        wr_byte[3] = wdata_q[7:0];
      end
    endcase
    case (nbytes)
      3'd1:    load_val = {{24{sign_ext & rd_byte[0][7]}}, rd_byte[0]};
      3'd2:    load_val = {{16{sign_ext & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      default: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    endcase
  end

  // Array write happens on the edge leaving ACCESS; all lanes commit on the
  // same edge, and an async reset during ACCESS drops state to IDLE so the
  // store is suppressed as a whole
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_store && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(nbytes)) mem[byte_addr[i]] <= wr_byte[i];
      end
    end
  end

  // Request capture and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q    <= opcode;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == ACCESS) begin
        err_q   <= access_err;
        rdata_q <= (access_err || is_store) ? 32'h0 : load_val;
      end
    end
  end

endmodule
